id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- Parametrised successor to the fixed ID→EX pipeline register bank.
- Carries NUM_FIELDS packed fields from ID to EX using a valid/ready handshake, replacing the ad-hoc stall/we/rst wiring.
- Optional one-entry skid buffer so in_ready is registered (breaks the EX→ID ready timing path).
- Per-field reset masking: bubbles and flushes insert NOP into the instruction field and leave non-reset fields (e.g. FP operands) untouched. Includes a saturating back-pressure counter for perf analysis.

Parameters:
DATA_WIDTH, 32, width of each field
NUM_FIELDS, 8, number of packed fields
INST_FIELD, 4, index of the field that resets to NOP_VAL; all other reset fields go to 0
NOP_VAL, 32'h00000013, reset/bubble value for INST_FIELD (addi x0,x0,0)
RST_MASK, 8'b0001_1111, bit i=1 → field i is cleared on reset/flush/bubble; bit i=0 → field i is never cleared
SKID, 1, 1 = main register plus one skid entry; 0 = main register only
CNT_WIDTH, 16, width of stall_cycles

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets)
flush  input  1  kill all held entries this cycle
in_valid  input  1  ID presents a decoded instruction
in_ready  output  1  pipe accepts in_data this cycle
in_data  input  NUM_FIELDS*DATA_WIDTH  field i at [i*DATA_WIDTH +: DATA_WIDTH]
out_valid  output  1  EX-side entry valid
out_ready  input  1  EX consumes the entry this cycle
out_data  output  NUM_FIELDS*DATA_WIDTH  main-register contents
occupancy  output  2  entries held (0..2; max 1 when SKID=0)
stall_cycles  output  CNT_WIDTH  saturating count of cycles with out_valid && !out_ready

Behaviour:
- State:
  - Main entry M: valid bit Mv plus data; out_valid=Mv, out_data=M.data.
  - Skid entry S: Sv plus data; exists only when SKID=1.
- Fire signals: in_fire = in_valid && in_ready; out_fire = Mv && out_ready.
- in_ready:
  - SKID=1: in_ready = !Sv, taken from a register (no combinational path from out_ready).
  - SKID=0: in_ready = !Mv || out_ready (combinational).
- Priority: reset > flush > normal.
- Reset (rst==0 at edge):
  - Mv=Sv=0, occupancy=0, stall_cycles=0.
  - Masked fields of M and S load their reset values (INST_FIELD→NOP_VAL, others→0).
  - Unmasked fields are not reset; the bench checks them only while out_valid=1.
- Flush (rst==1, flush==1):
  - Mv=Sv=0; masked fields load reset values; any in_fire in the same cycle is discarded.
  - stall_cycles is not cleared.
  - in_ready is 1 on the following cycle.
- Normal, M free (out_fire || !Mv):
  - if Sv: M←S, Sv←0;
  - else if in_fire: M←in_data, Mv←1;
  - else: Mv←0 and masked fields load reset values (bubble reads NOP on the inst field).
- Normal, M held (Mv && !out_ready): if in_fire (SKID=1 only), S←in_data, Sv←1.
- Ordering: FIFO order is preserved in all cases. Simultaneous in_fire and out_fire with Sv=0 gives a 1-cycle pass-through: the new entry is in M on the next cycle.
- Unmasked fields: load only on a real data transfer into that entry (in_fire or S→M); otherwise they hold their value.
- Latency: in_fire at cycle t → visible on out_data at t+1 when M is free.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- occupancy = Mv + Sv, registered.
- stall_cycles: increments each cycle with Mv && !out_ready; saturates at 2^CNT_WIDTH−1 (no wrap).
- Illegal stimulus: in_valid dropping while in_ready=0 is legal (no hold requirement on ID). The entry is simply not taken.

Test Plan:
- Reset: drive rst=0 for 2 cycles with in_valid=1 → out_valid=0, in_ready=1, out_data[INST_FIELD]=32'h00000013, masked fields 0, occupancy=0, stall_cycles=0.
- Streaming: out_ready=1, in_valid=1 with inst fields 0x00100093, 0x00200113, 0x00300193 on consecutive cycles → the same three values on out_data one cycle later each, no gaps, in_ready held 1.
- Back-pressure (SKID=1): out_ready=0 after accepting A, then send B → B goes to skid, occupancy=2, in_ready=0, C is not accepted. With out_ready=1, outputs are A then B in order; stall_cycles equals the held cycle count.
- Flush with both entries full plus in_valid=1 → next cycle out_valid=0, occupancy=0, inst field=NOP_VAL, an unmasked field (index 7) keeps its prior value, the incoming entry is dropped.
- Bubble: accept one entry, then in_valid=0, out_ready=1 → out_valid drops, inst field reads 32'h00000013.
- SKID=0 build: out_ready=0 with M full → in_ready=0 in the same cycle. Separately, with CNT_WIDTH=4 hold back-pressure 20 cycles → stall_cycles saturates at 15.

Source files
------------

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID to EX pipeline register with valid/ready handshake and optional skid entry
// Masked fields take reset values on reset, flush and bubble; unmasked fields hold until a real transfer.
module id_ex_pipe #(
  parameter int                        DATA_WIDTH = 32,
  parameter int                        NUM_FIELDS = 8,
  parameter int                        INST_FIELD = 4,
  parameter logic [DATA_WIDTH-1:0]     NOP_VAL    = 32'h00000013,
  parameter logic [NUM_FIELDS-1:0]     RST_MASK   = 8'b0001_1111,
  parameter int                        SKID       = 1,
  parameter int                        CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
  output logic [1:0]                       occupancy,
  output logic [CNT_WIDTH-1:0]             stall_cycles
);

  localparam int W = NUM_FIELDS * DATA_WIDTH;

  logic         m_valid, s_valid;
  logic [W-1:0] m_data, s_data;
  logic         m_valid_nxt, s_valid_nxt;
  logic [W-1:0] m_data_nxt, s_data_nxt;
  logic         in_fire, out_fire, m_free;

  function automatic logic [W-1:0] clear_fields(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (RST_MASK[i]) begin
        r[i*DATA_WIDTH +: DATA_WIDTH] = (i == INST_FIELD) ? NOP_VAL : '0;
      end
    end
    return r;
  endfunction

  // With a skid entry, in_ready depends only on the registered skid state.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !s_valid;
    end else begin : g_noskid
      assign in_ready = !m_valid || out_ready;
    end
  endgenerate

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;
  assign m_free    = out_fire || !m_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  always_comb begin
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    m_data_nxt  = m_data;
    s_data_nxt  = s_data;
    if (flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
      m_data_nxt  = clear_fields(m_data);
      s_data_nxt  = clear_fields(s_data);
    end else if (m_free) begin
      if (s_valid) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = s_data;
        s_valid_nxt = 1'b0;
      end else if (in_fire) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = in_data;
      end else begin
        m_valid_nxt = 1'b0;
        m_data_nxt  = clear_fields(m_data);
      end
    end else if (in_fire && (SKID != 0)) begin
      s_valid_nxt = 1'b1;
      s_data_nxt  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid      <= 1'b0;
      s_valid      <= 1'b0;
      m_data       <= clear_fields(m_data);
      s_data       <= clear_fields(s_data);
      occupancy    <= 2'd0;
      stall_cycles <= '0;
    end else begin
      m_valid   <= m_valid_nxt;
      s_valid   <= s_valid_nxt;
      m_data    <= m_data_nxt;
      s_data    <= s_data_nxt;
      occupancy <= {1'b0, m_valid_nxt} + {1'b0, s_valid_nxt};
      if (m_valid && !out_ready && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - scoreboard bench for id_ex_pipe (SKID=1 default build and SKID=0 CNT_WIDTH=4 build)
module tb_id_ex_pipe;

  localparam int W   = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic [15:0]  stall_cycles;

  logic         in_valid0 = 1'b0;
  logic         in_ready0;
  logic [W-1:0] in_data0 = '0;
  logic         out_valid0;
  logic         out_ready0 = 1'b0;
  logic [W-1:0] out_data0;
  logic [1:0]   occupancy0;
  logic [3:0]   stall_cycles0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  id_ex_pipe #(.SKID(0), .CNT_WIDTH(4)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cycles(stall_cycles0)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] sb[$];
  logic [15:0]  stall_m = '0;
  logic [31:0]  last7 = '0;
  bit           have7 = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] inst, input int tag);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'((tag << 8) | i);
    r[4*32 +: 32] = inst;
    return r;
  endfunction

  // One cycle: drive, check pre-edge handshake/output, advance the model, check post-edge state.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
    logic         exp_rdy;
    logic [W-1:0] e;
    int           size_before;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    #1;
    size_before = sb.size();
    exp_rdy = (size_before < 2);
    check_eq("in_ready", W'(in_ready), W'(exp_rdy));
    check_eq("out_valid", W'(out_valid), W'(size_before > 0));
    if (size_before > 0 && !ordy && stall_m != 16'hFFFF) stall_m++;
    if (fl) begin
      sb.delete();
    end else begin
      if (size_before > 0 && ordy) begin
        e = sb.pop_front();
        check_eq("out_data", out_data, e);
      end
      if (v && exp_rdy) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    check_eq("occupancy", W'(occupancy), W'(sb.size()));
    check_eq("stall_cycles", W'(stall_cycles), W'(stall_m));
    if (sb.size() > 0) begin
      last7 = sb[0][7*32 +: 32];
      have7 = 1;
    end else begin
      check_eq("bubble_inst", W'(out_data[4*32 +: 32]), W'(NOP));
      check_eq("bubble_f0", W'(out_data[0 +: 32]), '0);
      if (have7) check_eq("unmasked_f7", W'(out_data[7*32 +: 32]), W'(last7));
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = mk(32'hDEADBEEF, 9);
    in_valid0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", W'(out_valid), '0);
    check_eq("rst_in_ready", W'(in_ready), W'(1));
    check_eq("rst_inst", W'(out_data[4*32 +: 32]), W'(NOP));
    check_eq("rst_masked", W'(out_data[0 +: 128]), '0);
    check_eq("rst_occupancy", W'(occupancy), '0);
    check_eq("rst_stall", W'(stall_cycles), '0);
    check_eq("rst_stall0", W'(stall_cycles0), '0);
    rst = 1'b1;
    in_valid0 = 1'b0;

    // streaming then bubble
    step(1, mk(32'h00100093, 1), 1, 0);
    step(1, mk(32'h00200113, 2), 1, 0);
    step(1, mk(32'h00300193, 3), 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // back-pressure into the skid entry
    step(1, mk(32'h00400213, 4), 0, 0);
    step(1, mk(32'h00500293, 5), 0, 0);
    step(1, mk(32'h00600313, 6), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // flush with both entries full and an incoming entry
    step(1, mk(32'h00700393, 7), 0, 0);
    step(1, mk(32'h00800413, 8), 0, 0);
    step(1, mk(32'h00900493, 10), 0, 1);
    step(0, '0, 1, 0);

    for (int k = 0; k < 80; k++) begin
      step(1'($urandom_range(0, 1)), mk(32'h10000000 | 32'(k), 100 + k),
           1'(($urandom % 4) != 0), 1'(($urandom % 16) == 0));
    end
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // SKID=0 build: combinational ready and 4-bit saturating stall counter
    in_valid0 = 1'b1;
    in_data0 = mk(32'h00A00513, 11);
    out_ready0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b0;
    #1;
    check_eq("s0_in_ready_held", W'(in_ready0), '0);
    check_eq("s0_out_valid", W'(out_valid0), W'(1));
    check_eq("s0_out_inst", W'(out_data0[4*32 +: 32]), W'(32'h00A00513));
    check_eq("s0_occupancy", W'(occupancy0), W'(1));
    out_ready0 = 1'b1;
    #1;
    check_eq("s0_in_ready_free", W'(in_ready0), W'(1));
    out_ready0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("s0_stall_sat", W'(stall_cycles0), W'(15));
    check_eq("s0_still_valid", W'(out_valid0), W'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
